// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial sequencer around an external 8-bit adder slice: feeds the slice one
// operand byte pair per cycle, chains carry across bytes and streams result bytes.
module byte_serial_add_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_sub,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
  output logic       out_ovf
);

  localparam int              CNT_W    = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             is_first, is_last;

  // Operand stage (S0)
  logic       valid0;
  logic [7:0] a_q, b_q;
  logic       first_q, last_q, sub0_q;

  // Word-level chaining state
  logic carry_q, sub_q;

  logic s1_free, in_fire, s0_move;
  logic sub, ovf;

  assign s1_free  = !out_valid || out_ready;
  assign in_ready = !valid0 || s1_free;
  assign in_fire  = in_valid && in_ready;
  assign s0_move  = valid0 && s1_free;

  // ---------------------------------------------------------------------------
  // Word sequencing FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (in_fire) begin
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    is_first = (state == IDLE);
    is_last  = (state == BUSY) && (cnt == LAST_IDX);
  end

  // ---------------------------------------------------------------------------
  // S0: operand registers. A new byte may replace one leaving on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      sub0_q  <= 1'b0;
    end else if (in_fire) begin
      valid0  <= 1'b1;
      a_q     <= in_a;
      b_q     <= in_b;
      first_q <= is_first;
      last_q  <= is_last;
      if (is_first) sub0_q <= in_sub;
    end else if (s0_move) begin
      valid0 <= 1'b0;
    end
  end

  // Slice drive: the first byte takes its mode from the operand stage and its
  // carry-in from the mode (two's-complement +1); later bytes use the chain.
  always_comb begin
    sub     = first_q ? sub0_q : sub_q;
    add_a   = a_q;
    add_b   = sub ? ~b_q : b_q;
    add_cin = first_q ? sub : carry_q;
    ovf     = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
  end

  // ---------------------------------------------------------------------------
  // S1: result registers and carry/mode chain, updated as a byte leaves S0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
    end else if (s0_move) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= last_q;
      carry_q   <= add_cout;
      if (first_q) sub_q <= sub;
      if (last_q) begin
        out_cout <= add_cout;
        out_ovf  <= ovf;
      end else begin
        out_cout <= 1'b0;
        out_ovf  <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_flags_only_on_last : assert property (
    @(posedge clk) disable iff (!rst_n) (out_cout || out_ovf) |-> out_last);

  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_last)));

  a_idle_counter_clear : assert property (
    @(posedge clk) disable iff (!rst_n) (state == IDLE) |-> (cnt == '0));

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Bench for byte_serial_add_ctrl: table vectors, hand-written pipeline corner
// cases and randomized words checked against a word-level arithmetic model.
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = NB * 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sub;
  logic [7:0] in_a, in_b;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       out_valid, out_ready, out_last, out_cout, out_ovf;
  logic [7:0] out_sum;

  always #5 clk = ~clk;

  // Combinational 8-bit adder slice the controller sits around
  logic [8:0] slice_res;
  assign slice_res = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum   = slice_res[7:0];
  assign add_cout  = slice_res[8];

  byte_serial_add_ctrl #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int stalls = 0;
  int words_done = 0;
  bit bp_en = 1'b0;

  int   in_cyc[$];
  int   out_cyc[$];
  exp_t exp_q[$];
  res_t got_q[$];

  // Word-level reference state
  int           m_idx = 0;
  logic         m_sub = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;

  // Output word assembly
  int           got_idx = 0;
  logic [W-1:0] got_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Each accepted byte extends the operand words seen so far; byte k of the
  // full-width result depends only on bytes 0..k, so it is known immediately.
  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [W:0] full;
    exp_t       e;
    if (m_idx == 0) begin
      m_sub = s;
      m_a   = '0;
      m_b   = '0;
    end
    m_a[8*m_idx +: 8] = a;
    m_b[8*m_idx +: 8] = b;
    if (m_sub) full = {1'b0, m_a} + {1'b0, ~m_b} + {{W{1'b0}}, 1'b1};
    else       full = {1'b0, m_a} + {1'b0, m_b};
    e.sum  = full[8*m_idx +: 8];
    e.last = (m_idx == NB - 1);
    e.cout = e.last ? full[W] : 1'b0;
    if (m_sub) e.ovf = e.last && (m_a[W-1] != m_b[W-1]) && (full[W-1] != m_a[W-1]);
    else       e.ovf = e.last && (m_a[W-1] == m_b[W-1]) && (full[W-1] != m_a[W-1]);
    exp_q.push_back(e);
    m_idx = (m_idx + 1) % NB;
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_idx   = 0;
    got_idx = 0;
    got_acc = '0;
  endtask

  // Handshakes are stable between posedge+1 and the next posedge, so sample at negedge.
  always @(negedge clk) begin
    exp_t e;
    res_t r;
    if (rst_n) begin
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        model_accept(in_a, in_b, in_sub);
        in_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_out byte 0x%0h", out_sum));
        end else begin
          e = exp_q.pop_front();
          check("out_byte{sum,last,cout,ovf}",
                32'({out_sum, out_last, out_cout, out_ovf}),
                32'({e.sum, e.last, e.cout, e.ovf}));
        end
        got_acc[8*got_idx +: 8] = out_sum;
        if (out_last) begin
          r.sum  = got_acc;
          r.cout = out_cout;
          r.ovf  = out_ovf;
          got_q.push_back(r);
          words_done++;
          got_idx = 0;
          got_acc = '0;
        end else begin
          got_idx = (got_idx + 1) % NB;
        end
      end
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_byte(input logic [7:0] a, input logic [7:0] b, input logic s, input int gap);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) fail_now("in_accept_timeout");
  endtask

  // in_sub is randomized on non-first bytes; the DUT must ignore it there.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int max_gap);
    for (int k = 0; k < NB; k++)
      drive_byte(a[8*k +: 8], b[8*k +: 8], (k == 0) ? s : 1'($urandom),
                 (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic wait_words(input int target);
    for (int t = 0; t < 1000 && words_done < target; t++) begin
      @(posedge clk);
      #1;
    end
    if (words_done < target) fail_now("word_wait_timeout");
  endtask

  task automatic check_word(input string name, input logic [W-1:0] sum, input logic cout, input logic ovf);
    res_t r;
    if (got_q.size() == 0) begin
      fail_now({name, "_missing"});
    end else begin
      r = got_q.pop_front();
      check({name, "_sum"}, r.sum, sum);
      check({name, "_cout"}, 32'(r.cout), 32'(cout));
      check({name, "_ovf"}, 32'(r.ovf), 32'(ovf));
    end
  endtask

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wd0, bi, bo, st0;
    logic [W-1:0] ra, rb;
    int sel;

    tbl[0] = '{32'h12345678, 32'h0000FFFF, 1'b0, 32'h12355677, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[6] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_out_sum",   32'(out_sum),   32'(8'h00));
    check("rst_out_last",  32'(out_last),  32'(1'b0));
    check("rst_out_cout",  32'(out_cout),  32'(1'b0));
    check("rst_out_ovf",   32'(out_ovf),   32'(1'b0));
    check("rst_in_ready",  32'(in_ready),  32'(1'b1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("post_rst_in_ready",  32'(in_ready),  32'(1'b1));
    check("post_rst_add_cin",   32'(add_cin),   32'(1'b0));

    // Table vectors, streamed back-to-back (mode/carry must not leak between words)
    got_q.delete();
    wd0 = words_done;
    bi  = in_cyc.size();
    bo  = out_cyc.size();
    st0 = stalls;
    for (int i = 0; i < 9; i++) send_word(tbl[i].a, tbl[i].b, tbl[i].sub, 0);
    wait_words(wd0 + 9);
    for (int i = 0; i < 9; i++)
      check_word($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
    if (out_cyc.size() > bo && in_cyc.size() > bi)
      check("latency_cycles", 32'(out_cyc[bo] - in_cyc[bi]), 32'd2);
    else
      fail_now("latency_no_transfer");

    // Throughput: 3 words, one byte per cycle each way, no input stall
    got_q.delete();
    wd0 = words_done;
    bi  = in_cyc.size();
    bo  = out_cyc.size();
    st0 = stalls;
    for (int w = 0; w < 3; w++) send_word($urandom, $urandom, 1'($urandom), 0);
    wait_words(wd0 + 3);
    check("tput_stalls", 32'(stalls - st0), 32'd0);
    if (out_cyc.size() >= bo + 3 * NB && in_cyc.size() >= bi + 3 * NB) begin
      check("tput_in_span",  32'(in_cyc[bi + 3*NB - 1] - in_cyc[bi]),  32'(3*NB - 1));
      check("tput_out_span", 32'(out_cyc[bo + 3*NB - 1] - out_cyc[bo]), 32'(3*NB - 1));
    end else begin
      fail_now("tput_short");
    end

    // Backpressure mid-word: both stages fill, in_ready drops, S1 holds byte 0
    got_q.delete();
    wd0 = words_done;
    fork
      send_word(32'hA1B2C3D4, 32'h01020304, 1'b0, 0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready",  32'(in_ready),  32'(1'b0));
          check("bp_out_valid", 32'(out_valid), 32'(1'b1));
          check("bp_out_sum",   32'(out_sum),   32'(8'hD8));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_words(wd0 + 1);
    check_word("bp", 32'hA2B4C6D8, 1'b0, 1'b0);

    // Reset after two bytes: partial word discarded, next word starts fresh
    got_q.delete();
    drive_byte(8'h44, 8'h11, 1'b1, 0);
    drive_byte(8'h33, 8'h22, 1'b0, 0);
    check("pre_rst_out_valid", 32'(out_valid), 32'(1'b1));
    #1 rst_n = 1'b0;
    model_flush();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("mid_rst_out_sum",   32'(out_sum),   32'(8'h00));
    check("mid_rst_out_last",  32'(out_last),  32'(1'b0));
    check("mid_rst_out_cout",  32'(out_cout),  32'(1'b0));
    check("mid_rst_out_ovf",   32'(out_ovf),   32'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wd0 = words_done;
    send_word(32'h00000003, 32'h00000004, 1'b0, 0);
    wait_words(wd0 + 1);
    check_word("post_rst", 32'h00000007, 1'b0, 1'b0);

    // Randomized words with input gaps and downstream backpressure
    got_q.delete();
    wd0 = words_done;
    bp_en = 1'b1;
    for (int w = 0; w < 150; w++) begin
      sel = $urandom_range(0, 3);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 1) rb = ~ra;
      if (sel == 2) rb = ra;
      if (sel == 3) ra = 32'h7FFFFFFF ^ {31'd0, 1'($urandom)};
      send_word(ra, rb, 1'($urandom), 2);
    end
    wait_words(wd0 + 150);
    bp_en = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
